// File: rtl/write_arbiter.sv
// Shares one write submodule among NUM_PORTS requesters with a one-cycle ack per write.
// Define WRITE_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// state       | meaning
// IDLE        | waiting for any req; picks winner and latches addr/data
// ISSUE       | one-cycle wr_start to the submodule
// WAIT_BUSY   | waiting for the submodule to drop wr_done
// WAIT_DONE   | waiting for wr_done; captures wr_resp
// RESPOND     | ack pulse to the granted port
module write_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int GRANT_WDTH = 2,
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS*ADDR_WDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]           ack,
  output logic [RESP_WDTH-1:0]           rsp,
  output logic [GRANT_WDTH-1:0]          grant_id,
  output logic                           busy,
  output logic                           wr_start,
  output logic [ADDR_WDTH-1:0]           wr_addr,
  output logic [DATA_WDTH-1:0]           wr_data,
  input  logic                           wr_done,
  input  logic [RESP_WDTH-1:0]           wr_resp
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [GRANT_WDTH-1:0]   grant_id_q, grant_id_d;
  logic [ADDR_WDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_WDTH-1:0]    wr_data_q, wr_data_d;
  logic [RESP_WDTH-1:0]    rsp_q, rsp_d;

  logic                    found;
  logic [GRANT_WDTH-1:0]   pick;
  logic [ADDR_WDTH-1:0]    pick_addr;
  logic [DATA_WDTH-1:0]    pick_data;

`ifdef WRITE_ARBITER_FIXED_PRIO_EN
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        pick      = GRANT_WDTH'(i);
        pick_addr = req_addr[i*ADDR_WDTH +: ADDR_WDTH];
        pick_data = req_data[i*DATA_WDTH +: DATA_WDTH];
      end
    end
  end
`else
  logic [GRANT_WDTH-1:0]   last_grant_q, last_grant_d;

  // Two passes: ports above last_grant first, then wrap to the ports at or below it.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i] && (i > int'(last_grant_q))) begin
        found     = 1'b1;
        pick      = GRANT_WDTH'(i);
        pick_addr = req_addr[i*ADDR_WDTH +: ADDR_WDTH];
        pick_data = req_data[i*DATA_WDTH +: DATA_WDTH];
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i] && (i <= int'(last_grant_q))) begin
        found     = 1'b1;
        pick      = GRANT_WDTH'(i);
        pick_addr = req_addr[i*ADDR_WDTH +: ADDR_WDTH];
        pick_data = req_data[i*DATA_WDTH +: DATA_WDTH];
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == S_IDLE) && found) last_grant_d = pick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= GRANT_WDTH'(NUM_PORTS - 1);
    else        last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rsp_d      = rsp_q;
    wr_start   = 1'b0;
    ack        = '0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (found) begin
          grant_id_d = pick;
          wr_addr_d  = pick_addr;
          wr_data_d  = pick_data;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wr_start = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!wr_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (wr_done) begin
          rsp_d   = wr_resp;
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        ack     = NUM_PORTS'(1) << grant_id_q;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rsp_q      <= rsp_d;
    end
  end

  assign grant_id = grant_id_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rsp      = rsp_q;

endmodule
